// File: rtl/ar_pkg.sv
// Shared AR request types and sizing helpers for the read-request arbiter slice.
package ar_pkg;

    localparam int AR_ID_W    = 4;
    localparam int AR_ADDR_W  = 32;
    localparam int AR_LEN_W   = 8;
    localparam int AR_SIZE_W  = 3;
    localparam int AR_BURST_W = 2;
    localparam int AR_QOS_W   = 4;

    // Field order matches the outgoing request buffer entry.
    typedef struct packed {
        logic [AR_ID_W-1:0]    id;
        logic [AR_ADDR_W-1:0]  addr;
        logic [AR_LEN_W-1:0]   len;
        logic [AR_SIZE_W-1:0]  size;
        logic [AR_BURST_W-1:0] burst;
        logic [AR_QOS_W-1:0]   qos;
    } ar_entry_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ar_if.sv
// AR channel bundle between the arbiter and the outgoing request buffer.
interface ar_if #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender (
        output valid, id, addr, len, size, burst, qos,
        input  ready
    );

    modport receiver (
        input  valid, id, addr, len, size, burst, qos,
        output ready
    );
endinterface

// File: rtl/qos_rr_picker.sv
// Combinational picker: highest QoS wins, ties broken round-robin from rr_ptr upward.
module qos_rr_picker
    import ar_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int QOS_WIDTH = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]           valid,
    input  logic [NUM_REQ*QOS_WIDTH-1:0] qos,
    input  logic [IDX_W-1:0]             rr_ptr,
    output logic [NUM_REQ-1:0]           winner,
    output logic [IDX_W-1:0]             winner_idx,
    output logic                         any_valid
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [QOS_WIDTH-1:0] max_qos;
    logic [NUM_REQ-1:0]   top_level;
    logic [IDX_W:0]       scan_sum;
    logic [IDX_W-1:0]     scan_idx;
    logic                 found;

    // NOTE: every variable gets a default before any conditional update, so no path infers a latch.
    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid[i] && (qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)) begin
                max_qos = qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
    end

    always_comb begin
        top_level = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            top_level[i] = valid[i] && (qos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
        end
    end

    // Walk from rr_ptr upward with wrap; the first top-QoS requester met wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!found && top_level[scan_idx]) begin
                found            = 1'b1;
                winner[scan_idx] = 1'b1;
                winner_idx       = scan_idx;
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/ar_request_arbiter.sv
// Arbitrates NUM_REQ AR requesters onto one registered AR sender with a read-credit cap.
module ar_request_arbiter
    import ar_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int SIZE_WIDTH      = 3,
    parameter int BURST_WIDTH     = 2,
    parameter int QOS_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W          = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ID_WIDTH-1:0]      req_id,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
    input  logic [NUM_REQ*SIZE_WIDTH-1:0]    req_size,
    input  logic [NUM_REQ*BURST_WIDTH-1:0]   req_burst,
    input  logic [NUM_REQ*QOS_WIDTH-1:0]     req_qos,
    ar_if.sender                             ar_out,
    input  logic                             r_done,
    output logic [CNT_W-1:0]                 outstanding_cnt,
    output logic                             credit_err
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]     winner;
    logic [IDX_W-1:0]       winner_idx;
    logic                   any_valid;
    logic                   load;
    logic                   credit_ret;

    logic [ID_WIDTH-1:0]    sel_id;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic [SIZE_WIDTH-1:0]  sel_size;
    logic [BURST_WIDTH-1:0] sel_burst;
    logic [QOS_WIDTH-1:0]   sel_qos;

    logic                   valid_q,  valid_d;
    logic [ID_WIDTH-1:0]    id_q,     id_d;
    logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
    logic [LEN_WIDTH-1:0]   len_q,    len_d;
    logic [SIZE_WIDTH-1:0]  size_q,   size_d;
    logic [BURST_WIDTH-1:0] burst_q,  burst_d;
    logic [QOS_WIDTH-1:0]   qos_q,    qos_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   err_q,    err_d;

    qos_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .QOS_WIDTH (QOS_WIDTH),
        .IDX_W     (IDX_W)
    ) u_picker (
        .valid      (req_valid),
        .qos        (req_qos),
        .rr_ptr     (rr_ptr_q),
        .winner     (winner),
        .winner_idx (winner_idx),
        .any_valid  (any_valid)
    );

    // Gating with rst keeps requesters from seeing a grant the reset edge would discard.
    assign load       = ~rst & (~valid_q | ar_out.ready) & any_valid & (cnt_q < MAX_CNT);
    assign req_ready  = {NUM_REQ{load}} & winner;
    assign credit_ret = r_done & (cnt_q != '0);

    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        sel_qos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                sel_id    = req_id[i*ID_WIDTH +: ID_WIDTH];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
                sel_size  = req_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                sel_burst = req_burst[i*BURST_WIDTH +: BURST_WIDTH];
                sel_qos   = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        qos_d    = qos_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            valid_d  = 1'b1;
            id_d     = sel_id;
            addr_d   = sel_addr;
            len_d    = sel_len;
            size_d   = sel_size;
            burst_d  = sel_burst;
            qos_d    = sel_qos;
            rr_ptr_d = (winner_idx == LAST_IDX) ? '0 : winner_idx + 1'b1;
        end else if (ar_out.ready) begin
            valid_d = 1'b0;
        end
    end

    // Credits are reserved at capture; a return with nothing outstanding is only flagged.
    always_comb begin
        cnt_d = cnt_q;
        case ({load, credit_ret})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (r_done & (cnt_q == '0));
    end

    // NOTE: state flops use non-blocking assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            qos_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            qos_q    <= qos_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign ar_out.valid    = valid_q;
    assign ar_out.id       = id_q;
    assign ar_out.addr     = addr_q;
    assign ar_out.len      = len_q;
    assign ar_out.size     = size_q;
    assign ar_out.burst    = burst_q;
    assign ar_out.qos      = qos_q;
    assign outstanding_cnt = cnt_q;
    assign credit_err      = err_q;

endmodule

// File: tb/tb_ar_request_arbiter.sv
// Scoreboard bench: a QoS/round-robin reference model predicts grants; a monitor checks each AR handshake.
module tb_ar_request_arbiter;
    import ar_pkg::*;

    localparam int N       = 4;
    localparam int MAX_OUT = 4;
    localparam int CW      = cnt_width(MAX_OUT);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N*AR_ID_W-1:0]    req_id;
    logic [N*AR_ADDR_W-1:0]  req_addr;
    logic [N*AR_LEN_W-1:0]   req_len;
    logic [N*AR_SIZE_W-1:0]  req_size;
    logic [N*AR_BURST_W-1:0] req_burst;
    logic [N*AR_QOS_W-1:0]   req_qos;
    logic                    r_done;
    logic [CW-1:0]           outstanding_cnt;
    logic                    credit_err;

    ar_if #(
        .ID_WIDTH(AR_ID_W), .ADDR_WIDTH(AR_ADDR_W), .LEN_WIDTH(AR_LEN_W),
        .SIZE_WIDTH(AR_SIZE_W), .BURST_WIDTH(AR_BURST_W), .QOS_WIDTH(AR_QOS_W)
    ) ar_bus ();

    ar_request_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(AR_ID_W), .ADDR_WIDTH(AR_ADDR_W), .LEN_WIDTH(AR_LEN_W),
        .SIZE_WIDTH(AR_SIZE_W), .BURST_WIDTH(AR_BURST_W), .QOS_WIDTH(AR_QOS_W),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst), .req_qos(req_qos),
        .ar_out(ar_bus),
        .r_done(r_done), .outstanding_cnt(outstanding_cnt), .credit_err(credit_err)
    );

    int checks = 0;
    int passes = 0;
    ar_entry_t exp_q[$];

    logic m_valid;
    int   m_ptr;
    int   m_cnt;
    logic m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Best requester = highest qos, then nearest at-or-after the pointer.
    function automatic int model_pick(input logic [N-1:0] v, input logic [N*AR_QOS_W-1:0] q, input int ptr);
        int best = -1;
        int best_score = -1;
        int score;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                score = int'(q[i*AR_QOS_W +: AR_QOS_W]) * N + (N - 1 - ((i - ptr + N) % N));
                if (score > best_score) begin
                    best_score = score;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic ar_entry_t entry_of(input int i);
        ar_entry_t e;
        e.id    = req_id[i*AR_ID_W +: AR_ID_W];
        e.addr  = req_addr[i*AR_ADDR_W +: AR_ADDR_W];
        e.len   = req_len[i*AR_LEN_W +: AR_LEN_W];
        e.size  = req_size[i*AR_SIZE_W +: AR_SIZE_W];
        e.burst = req_burst[i*AR_BURST_W +: AR_BURST_W];
        e.qos   = req_qos[i*AR_QOS_W +: AR_QOS_W];
        return e;
    endfunction

    function automatic ar_entry_t bus_entry();
        ar_entry_t e;
        e.id    = ar_bus.id;
        e.addr  = ar_bus.addr;
        e.len   = ar_bus.len;
        e.size  = ar_bus.size;
        e.burst = ar_bus.burst;
        e.qos   = ar_bus.qos;
        return e;
    endfunction

    task automatic step(input logic rst_v, input logic [N-1:0] v, input logic [N*AR_QOS_W-1:0] q,
                        input logic rdy, input logic rd);
        int            w;
        logic          load_e;
        logic          dec;
        logic [N-1:0]  exp_ready;
        @(negedge clk);
        rst          = rst_v;
        req_valid    = v;
        req_qos      = q;
        ar_bus.ready = rdy;
        r_done       = rd;
        req_id       = (N*AR_ID_W)'($urandom);
        req_addr     = {$urandom, $urandom, $urandom, $urandom};
        req_len      = $urandom;
        req_size     = (N*AR_SIZE_W)'($urandom);
        req_burst    = (N*AR_BURST_W)'($urandom);
        #1;
        check("out_valid", ar_bus.valid, m_valid);
        check("outstanding_cnt", outstanding_cnt, m_cnt);
        check("credit_err", credit_err, m_err);
        w = model_pick(v, q, m_ptr);
        load_e = !rst_v && (!m_valid || rdy) && (w >= 0) && (m_cnt < MAX_OUT);
        exp_ready = load_e ? N'(1 << w) : '0;
        check("req_ready", req_ready, exp_ready);
        if (rst_v) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            dec   = rd && (m_cnt > 0);
            m_err = m_err | (rd && (m_cnt == 0));
            m_cnt = m_cnt + (load_e ? 1 : 0) - (dec ? 1 : 0);
            if (load_e) begin
                exp_q.push_back(entry_of(w));
                m_ptr   = (w + 1) % N;
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Monitor: checks AXI hold stability and pops one expectation per handshake.
    logic      have_prev = 1'b0;
    logic      prev_valid;
    logic      prev_ready;
    ar_entry_t prev_pl;
    ar_entry_t got;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev && prev_valid && !prev_ready) begin
                    check("hold_valid", ar_bus.valid, 1'b1);
                    check("hold_payload", 64'(bus_entry()), 64'(prev_pl));
                end
                if (ar_bus.valid && ar_bus.ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_handshake", 64'(bus_entry()), 64'hDEAD_0000_0000_0000);
                    end else begin
                        got = exp_q.pop_front();
                        check("handshake_payload", 64'(bus_entry()), 64'(got));
                    end
                end
                prev_valid = ar_bus.valid;
                prev_ready = ar_bus.ready;
                prev_pl    = bus_entry();
                have_prev  = 1'b1;
            end
        end
    end

    logic [N*AR_QOS_W-1:0] rq;

    initial begin
        rst = 1'b1; req_valid = '0; req_qos = '0; ar_bus.ready = 1'b0; r_done = 1'b0;
        req_id = '0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
        m_valid = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, with a valid request presented during reset
        step(1'b1, 4'b1111, '0, 1'b1, 1'b0);
        check("reset_payload", 64'(bus_entry()), 64'd0);

        // Single request from requester 0
        step(1'b0, 4'b0001, '0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, '0, 1'b1, 1'b0);

        // Equal qos round-robin with pointer wrap; r_done keeps the count steady
        repeat (6) step(1'b0, 4'b1111, '0, 1'b1, 1'b1);

        // req3 qos 7 beats req1 qos 2 until req3 drops
        repeat (3) step(1'b0, 4'b1010, {4'd7, 4'd0, 4'd2, 4'd0}, 1'b1, 1'b1);
        repeat (2) step(1'b0, 4'b0010, {4'd7, 4'd0, 4'd2, 4'd0}, 1'b1, 1'b1);

        // Downstream stall for 5 cycles, then handshake with same-cycle reload
        step(1'b0, 4'b1111, '0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 4'b1111, '0, 1'b0, 1'b0);
        step(1'b0, 4'b1111, '0, 1'b1, 1'b0);

        // Drain credits, then fill to the cap and release one
        for (int i = 0; i < 16 && m_cnt > 0; i++) step(1'b0, 4'b0000, '0, 1'b1, 1'b1);
        repeat (MAX_OUT + 2) step(1'b0, 4'b1111, '0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, '0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 4'b1111, '0, 1'b1, 1'b0);

        // Spurious r_done sets the sticky error; reset clears it mid-hold
        step(1'b1, 4'b0000, '0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, '0, 1'b0, 1'b1);
        step(1'b0, 4'b0000, '0, 1'b0, 1'b0);
        step(1'b0, 4'b0100, '0, 1'b0, 1'b0);
        step(1'b0, 4'b0100, '0, 1'b0, 1'b0);
        step(1'b1, 4'b0100, '0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, '0, 1'b0, 1'b0);

        // Random traffic with narrow qos range to force frequent ties
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) rq[i*AR_QOS_W +: AR_QOS_W] = AR_QOS_W'($urandom_range(0, 3));
            step(($urandom % 500) == 0, N'($urandom), rq, ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        repeat (4) step(1'b0, 4'b0000, '0, 1'b1, 1'b0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ar_request_arbiter.md
Name: ar_request_arbiter

Overview:
- Shares the single outgoing AR path between NUM_REQ upstream requesters (ordering-unit lanes) and feeds the outgoing request buffer through an ar_if sender.
- Selects by highest QoS, with round-robin among equal-QoS requesters.
- Holds each selected request stable until handshake.
- Caps outstanding read bursts using a credit counter; completed bursts return credits.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 4, AR id width.
- ADDR_WIDTH, 32, AR address width.
- LEN_WIDTH, 8, AR len width.
- SIZE_WIDTH, 3, AR size width.
- BURST_WIDTH, 2, AR burst width.
- QOS_WIDTH, 4, AR qos width.
- MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted reads (1..255).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester AR valid.
- req_ready  output  NUM_REQ  per-requester AR ready.
- req_id  input  NUM_REQ*ID_WIDTH  packed per-requester id (requester i at slice i).
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses.
- req_len  input  NUM_REQ*LEN_WIDTH  packed lengths.
- req_size  input  NUM_REQ*SIZE_WIDTH  packed sizes.
- req_burst  input  NUM_REQ*BURST_WIDTH  packed burst types.
- req_qos  input  NUM_REQ*QOS_WIDTH  packed QoS.
- ar_out  ar_if.sender  -  registered AR toward the outgoing request buffer.
- r_done  input  1  one-cycle pulse per completed read burst (R handshake with rlast); returns one credit.
- outstanding_cnt  output  $clog2(MAX_OUTSTANDING+1)  current credit usage.
- credit_err  output  1  sticky flag, set when r_done arrives while outstanding_cnt==0.

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - ar_out.valid=0 and all ar_out payload fields=0.
  - req_ready=0, rr_ptr=0, outstanding_cnt=0, credit_err=0.
  - Any held request is dropped; its requester must re-present it.
- Eligible requester i: req_valid[i]=1.
- Winner selection (combinational):
  - Find max qos among eligible requesters.
  - Among requesters at that qos, take the first at or after rr_ptr, scanning upward modulo NUM_REQ.
  - Winner is a one-hot vector, zero if none eligible.
- Load condition: load = (~ar_out.valid | ar_out.ready) & any_eligible & (outstanding_cnt < MAX_OUTSTANDING).
- req_ready[i] = load & winner[i]:
  - Combinational and at most one-hot.
  - May depend on req_valid; never asserted to a non-winner.
- On load at posedge:
  - Winner payload is copied into the output register; ar_out.valid is set to 1.
  - rr_ptr <= winner index + 1, wrapping NUM_REQ-1 -> 0.
  - A credit is reserved at capture, not at downstream handshake.
- Output hold: while ar_out.valid=1 and ar_out.ready=0, the payload and valid stay constant (AXI stability) and req_ready is all 0.
- Handshake (ar_out.valid & ar_out.ready):
  - If load is also true in the same cycle, the next winner is captured; back-to-back issue, no bubble.
  - Otherwise ar_out.valid <= 0 and the payload holds its last value.
- Latency: request to ar_out.valid is 1 cycle minimum; sustained throughput is 1 request per cycle.
- Credits (outstanding_cnt):
  - load only: +1.
  - r_done only (cnt>0): -1.
  - Both in the same cycle: unchanged.
  - r_done at cnt==0: unchanged, credit_err <= 1 (cleared only by rst).
  - At cnt==MAX_OUTSTANDING: load is blocked. An r_done in that cycle frees the credit for the next cycle; it does not enable a same-cycle load.
- Starvation: a lower-QoS requester can wait indefinitely under sustained higher-QoS traffic; this is accepted by design. Within one QoS level, round-robin guarantees service within NUM_REQ grants.

Decomposition:
- Shared package ar_pkg: ar_entry_t (id, addr, len, size, burst, qos packed struct, same field order as the buffer), and a helper constant/function for counter width ($clog2(MAX+1)).
- Sub-module: qos_rr_picker (combinational). Inputs: valid vector, packed qos, rr_ptr. Outputs: one-hot winner, winner index, any_valid.
- Arbiter top owns the output register, rr_ptr, credit counter and error flag.

Test Plan:
- Reset, then req_valid=0001 with qos 0 and ar_out.ready=1 -> req_ready=0001 that cycle; next cycle ar_out.valid=1 with req0 payload; outstanding_cnt=1.
- All 4 requesters valid, equal qos=0, ready held high -> grant order 0,1,2,3,0 on consecutive cycles; rr_ptr wraps 3->0.
- req1 qos=2, req3 qos=7, both valid -> req3 granted first, then req1 only after req3 drops valid.
- ar_out.ready=0 for 5 cycles with ar_out.valid=1 -> payload bit-stable, req_ready=0000 throughout; on ready=1, next winner loads the same cycle.
- MAX_OUTSTANDING=2, three valid requests, no r_done -> exactly 2 accepted, third stalls with req_ready=0. Pulse r_done -> next cycle third accepted; load and r_done in the same cycle leave cnt unchanged at 2.
- r_done pulse after reset with cnt=0 -> credit_err=1, cnt stays 0; assert rst -> credit_err=0 and ar_out.valid=0 mid-hold.
